intr_ccr_sequencer: RTL and testbench
=====================================

Name: intr_ccr_sequencer

Overview:
- Interrupt entry/exit sequencer that drives the condition-code register's save/restore controls.
- On an external interrupt it performs these steps in order: freezes fetch, waits for the pipeline to drain, saves the flags (shift-left strobe), pushes the return PC and fetches the vector. It then redirects the PC.
- On RTI it restores the flags (shift-right strobe).
- Sits between the hazard/fetch unit, the stack/memory port and the flag register in the 8-bit pipelined core.

Parameters:
- ADDR_W, 8, PC / memory address width.
- VEC_ADDR, 8'h01, memory address holding the interrupt vector.
- SYNC_STAGES, 2, synchronizer flops on INTR (minimum 2).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- INTR  in  1  external interrupt request, asynchronous level; a rising edge requests service.
- Pipe_Empty  in  1  high when no instruction is in flight past fetch.
- Is_RTI  in  1  one-cycle strobe from writeback: an RTI retired.
- PC_in  in  ADDR_W  PC of the next instruction to resume.
- Stack_Ack  in  1  stack port accepted the push this cycle.
- Vec_Valid  in  1  Vec_Data is valid this cycle.
- Vec_Data  in  ADDR_W  vector read data.
- Freeze  out  1  stall fetch and suppress new flag writes.
- CCR_Save  out  1  to flag register Shift_Left.
- CCR_Restore  out  1  to flag register Shift_Right.
- Stack_Push  out  1  push request.
- Stack_Data  out  ADDR_W  return PC being pushed.
- Vec_Rd  out  1  vector read request.
- Vec_Addr  out  ADDR_W  constant VEC_ADDR while Vec_Rd=1, else 0.
- PC_Load  out  1  one-cycle PC redirect.
- PC_Load_Val  out  ADDR_W  redirect target.
- In_Service  out  1  handler running.

Behaviour:
- Reset (async):
  - State goes to IDLE; the synchronizer, the edge register, the pending bit, ret_pc and vec_reg all go to 0.
  - Every output is 0 while RST is high and after its release.
  - Reset mid-sequence abandons the sequence; no further strobes are issued.
- Edge detect:
  - INTR passes through SYNC_STAGES flops. The pending bit is set at the edge where sync_out=1 and the previous sync_out=0.
  - With default parameters, INTR rising before edge k sets pending at edge k+2.
  - INTR held high through reset release counts as a new edge.
  - Pending is one-deep: further edges while pending=1 are lost. Edges during SERVICE/RESTORE are latched and taken after IDLE is re-entered.
- FSM (Moore outputs):
  - IDLE: all outputs 0. Goes to DRAIN if pending=1.
  - DRAIN: Freeze=1. Goes to SAVE in the cycle Pipe_Empty=1; otherwise stays in DRAIN.
  - SAVE: Freeze=1, CCR_Save=1 for exactly one cycle. ret_pc <= PC_in. Goes to PUSH.
  - PUSH: Freeze=1, Stack_Push=1, Stack_Data=ret_pc. Held until Stack_Ack=1, then goes to FETCH_VEC.
  - FETCH_VEC: Freeze=1, Vec_Rd=1, Vec_Addr=VEC_ADDR. On Vec_Valid=1, vec_reg <= Vec_Data and goes to LOAD_PC.
  - LOAD_PC: Freeze=1, PC_Load=1, PC_Load_Val=vec_reg for one cycle. Clears pending; an edge arriving in this same cycle wins and pending stays 1. Goes to SERVICE.
  - SERVICE: In_Service=1, Freeze=0. Goes to RESTORE on Is_RTI=1.
  - RESTORE: CCR_Restore=1, In_Service=1 for one cycle. Goes to IDLE.
- Is_RTI outside SERVICE is ignored; CCR_Restore is never asserted outside RESTORE.
- No nesting: the flag register holds one saved nibble, so a new interrupt is never entered before RESTORE completes.
- CCR_Save and CCR_Restore are never high together; each pulse is exactly one cycle.
- Minimum latency, pending set to PC_Load with Pipe_Empty, Stack_Ack and Vec_Valid all held at 1: 5 cycles (DRAIN, SAVE, PUSH, FETCH_VEC, LOAD_PC).
- PC_Load_Val is 0 when PC_Load=0. Stack_Data is 0 when Stack_Push=0.

Test Plan:
- Basic entry: RST released, INTR 0->1; Pipe_Empty, Stack_Ack and Vec_Valid held at 1; PC_in=8'h3A; Vec_Data=8'hC0 -> Freeze rises within 4 cycles. CCR_Save pulses one cycle. Stack_Push occurs with Stack_Data=8'h3A. Vec_Addr=8'h01. PC_Load=1 with PC_Load_Val=8'hC0, then In_Service=1.
- Drain/backpressure: Pipe_Empty low 3 cycles, Stack_Ack delayed 2 cycles, Vec_Valid delayed 4 cycles -> state holds in each wait state; Freeze stays 1; only one CCR_Save pulse and only one PC_Load pulse.
- Exit: in SERVICE pulse Is_RTI -> CCR_Restore=1 exactly one cycle, In_Service falls the next cycle, state returns to IDLE. Is_RTI pulsed in IDLE -> no CCR_Restore.
- Nested request: second INTR edge during SERVICE -> no Freeze until after RESTORE; then a full second entry sequence. Three edges during SERVICE -> only one extra entry.
- Reset mid-op: assert RST in PUSH -> all outputs 0 immediately (async). After release with INTR low, the FSM stays in IDLE.
- Glitch/level: INTR held high for 20 cycles -> exactly one entry. Pulse shorter than one CLK period captured by the synchronizer -> one entry. Pulse not captured -> no entry.

Source files
------------

// File: rtl/intr_ccr_sequencer.sv
// Interrupt entry/exit sequencer: freezes fetch, drains, saves flags, pushes the
// return PC, fetches the vector and redirects the PC; RTI restores the flags.
module intr_ccr_sequencer #(
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] VEC_ADDR    = 8'h01,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              INTR,
    input  logic              Pipe_Empty,
    input  logic              Is_RTI,
    input  logic [ADDR_W-1:0] PC_in,
    input  logic              Stack_Ack,
    input  logic              Vec_Valid,
    input  logic [ADDR_W-1:0] Vec_Data,
    output logic              Freeze,
    output logic              CCR_Save,
    output logic              CCR_Restore,
    output logic              Stack_Push,
    output logic [ADDR_W-1:0] Stack_Data,
    output logic              Vec_Rd,
    output logic [ADDR_W-1:0] Vec_Addr,
    output logic              PC_Load,
    output logic [ADDR_W-1:0] PC_Load_Val,
    output logic              In_Service
);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE,
        PUSH,
        FETCH_VEC,
        LOAD_PC,
        SERVICE,
        RESTORE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   r_pending;
    logic [ADDR_W-1:0]      r_ret_pc;
    logic [ADDR_W-1:0]      r_vec;

    logic w_sync_out;
    logic w_edge;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_sync_out & ~r_sync_prev;

    // Synchronizer, edge register and one-deep pending request
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], INTR};
            r_sync_prev <= w_sync_out;
            // A new edge in the LOAD_PC cycle outranks the clear
            r_pending   <= w_edge | (r_pending & (r_state != LOAD_PC));
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ret_pc <= '0;
            r_vec    <= '0;
        end else begin
            if (r_state == SAVE) begin
                r_ret_pc <= PC_in;
            end
            if (r_state == FETCH_VEC && Vec_Valid) begin
                r_vec <= Vec_Data;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        Freeze       = 1'b0;
        CCR_Save     = 1'b0;
        CCR_Restore  = 1'b0;
        Stack_Push   = 1'b0;
        Stack_Data   = '0;
        Vec_Rd       = 1'b0;
        Vec_Addr     = '0;
        PC_Load      = 1'b0;
        PC_Load_Val  = '0;
        In_Service   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pending) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                Freeze = 1'b1;
                if (Pipe_Empty) begin
                    w_state_next = SAVE;
                end
            end
            SAVE: begin
                Freeze       = 1'b1;
                CCR_Save     = 1'b1;
                w_state_next = PUSH;
            end
            PUSH: begin
                Freeze     = 1'b1;
                Stack_Push = 1'b1;
                Stack_Data = r_ret_pc;
                if (Stack_Ack) begin
                    w_state_next = FETCH_VEC;
                end
            end
            FETCH_VEC: begin
                Freeze   = 1'b1;
                Vec_Rd   = 1'b1;
                Vec_Addr = VEC_ADDR;
                if (Vec_Valid) begin
                    w_state_next = LOAD_PC;
                end
            end
            LOAD_PC: begin
                Freeze       = 1'b1;
                PC_Load      = 1'b1;
                PC_Load_Val  = r_vec;
                w_state_next = SERVICE;
            end
            SERVICE: begin
                In_Service = 1'b1;
                if (Is_RTI) begin
                    w_state_next = RESTORE;
                end
            end
            RESTORE: begin
                CCR_Restore  = 1'b1;
                In_Service   = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_ccr_sequencer.sv
// Directed self-checking bench for intr_ccr_sequencer.
module tb_intr_ccr_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       INTR;
    logic       Pipe_Empty;
    logic       Is_RTI;
    logic [7:0] PC_in;
    logic       Stack_Ack;
    logic       Vec_Valid;
    logic [7:0] Vec_Data;
    logic       Freeze;
    logic       CCR_Save;
    logic       CCR_Restore;
    logic       Stack_Push;
    logic [7:0] Stack_Data;
    logic       Vec_Rd;
    logic [7:0] Vec_Addr;
    logic       PC_Load;
    logic [7:0] PC_Load_Val;
    logic       In_Service;

    int errors = 0;
    int checks = 0;

    int n_save = 0;
    int n_pcl = 0;
    int n_rest = 0;
    int n_overlap = 0;
    int n_long = 0;
    logic prev_save = 1'b0;
    logic prev_rest = 1'b0;

    int base_save;
    int base_pcl;
    int base_rest;

    always #5 CLK = ~CLK;

    intr_ccr_sequencer dut (
        .CLK         (CLK),
        .RST         (RST),
        .INTR        (INTR),
        .Pipe_Empty  (Pipe_Empty),
        .Is_RTI      (Is_RTI),
        .PC_in       (PC_in),
        .Stack_Ack   (Stack_Ack),
        .Vec_Valid   (Vec_Valid),
        .Vec_Data    (Vec_Data),
        .Freeze      (Freeze),
        .CCR_Save    (CCR_Save),
        .CCR_Restore (CCR_Restore),
        .Stack_Push  (Stack_Push),
        .Stack_Data  (Stack_Data),
        .Vec_Rd      (Vec_Rd),
        .Vec_Addr    (Vec_Addr),
        .PC_Load     (PC_Load),
        .PC_Load_Val (PC_Load_Val),
        .In_Service  (In_Service)
    );

    // Pulse counters sampled mid-cycle
    always @(negedge CLK) begin
        if (CCR_Save) n_save <= n_save + 1;
        if (PC_Load) n_pcl <= n_pcl + 1;
        if (CCR_Restore) n_rest <= n_rest + 1;
        if (CCR_Save && CCR_Restore) n_overlap <= n_overlap + 1;
        if ((CCR_Save && prev_save) || (CCR_Restore && prev_rest)) n_long <= n_long + 1;
        prev_save <= CCR_Save;
        prev_rest <= CCR_Restore;
    end

    function automatic logic [30:0] mk(input logic frz, input logic sav, input logic rst_o,
                                       input logic psh, input logic [7:0] sd, input logic vrd,
                                       input logic [7:0] va, input logic pcl, input logic [7:0] pcv,
                                       input logic svc);
        return {frz, sav, rst_o, psh, sd, vrd, va, pcl, pcv, svc};
    endfunction

    function automatic logic [30:0] outs();
        return {Freeze, CCR_Save, CCR_Restore, Stack_Push, Stack_Data, Vec_Rd, Vec_Addr,
                PC_Load, PC_Load_Val, In_Service};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_o(input string tag, input logic [30:0] exp);
        chk(tag, {1'b0, outs()}, {1'b0, exp});
        $display("step %-14s outs=%h exp=%h", tag, outs(), exp);
    endtask

    logic [30:0] O_IDLE;
    logic [30:0] O_DRAIN;
    logic [30:0] O_SAVE;
    logic [30:0] O_FETCH;
    logic [30:0] O_SERVICE;
    logic [30:0] O_RESTORE;

    initial begin
        O_IDLE    = '0;
        O_DRAIN   = mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        O_SAVE    = mk(1, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
        O_FETCH   = mk(1, 0, 0, 0, 8'h00, 1, 8'h01, 0, 8'h00, 0);
        O_SERVICE = mk(0, 0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1);
        O_RESTORE = mk(0, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1);

        RST = 1'b1; INTR = 1'b0; Pipe_Empty = 1'b1; Is_RTI = 1'b0; PC_in = 8'h3A;
        Stack_Ack = 1'b1; Vec_Valid = 1'b1; Vec_Data = 8'hC0;
        tick(); tick();
        chk_o("reset_held", O_IDLE);
        RST = 1'b0;
        tick(); tick();
        chk_o("reset_release", O_IDLE);

        // Basic entry: INTR rises before edge k, pending at k+2, DRAIN at k+3
        INTR = 1'b1;
        tick(); tick(); tick();
        chk_o("basic_idle_k2", O_IDLE);
        tick(); chk_o("basic_drain", O_DRAIN);
        tick(); chk_o("basic_save", O_SAVE);
        tick(); chk_o("basic_push", mk(1, 0, 0, 1, 8'h3A, 0, 8'h00, 0, 8'h00, 0));
        tick(); chk_o("basic_fetch", O_FETCH);
        tick(); chk_o("basic_load", mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hC0, 0));
        tick(); chk_o("basic_service", O_SERVICE);
        tick(); tick();
        chk_o("service_hold", O_SERVICE);

        // Exit
        Is_RTI = 1'b1;
        tick(); Is_RTI = 1'b0;
        chk_o("exit_restore", O_RESTORE);
        tick(); chk_o("exit_idle", O_IDLE);
        // INTR still high: no new edge, no re-entry
        repeat (8) tick();
        chk_o("level_no_reentry", O_IDLE);
        base_rest = n_rest;
        Is_RTI = 1'b1;
        tick(); Is_RTI = 1'b0;
        chk_o("rti_in_idle", O_IDLE);
        tick();
        chk("rti_idle_no_rest", n_rest, base_rest);
        INTR = 1'b0;
        repeat (4) tick();

        // Drain / backpressure
        Pipe_Empty = 1'b0; Stack_Ack = 1'b0; Vec_Valid = 1'b0; PC_in = 8'h55; Vec_Data = 8'h9A;
        base_save = n_save; base_pcl = n_pcl;
        INTR = 1'b1;
        tick(); tick(); INTR = 1'b0;
        tick(); chk_o("bp_idle", O_IDLE);
        tick(); chk_o("bp_drain1", O_DRAIN);
        tick(); tick(); chk_o("bp_drain3", O_DRAIN);
        Pipe_Empty = 1'b1;
        tick(); chk_o("bp_save", O_SAVE);
        tick(); chk_o("bp_push1", mk(1, 0, 0, 1, 8'h55, 0, 8'h00, 0, 8'h00, 0));
        tick(); chk_o("bp_push2", mk(1, 0, 0, 1, 8'h55, 0, 8'h00, 0, 8'h00, 0));
        Stack_Ack = 1'b1;
        tick(); Stack_Ack = 1'b0; chk_o("bp_fetch1", O_FETCH);
        tick(); tick(); tick(); chk_o("bp_fetch4", O_FETCH);
        Vec_Valid = 1'b1;
        tick(); chk_o("bp_load", mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h9A, 0));
        tick(); chk_o("bp_service", O_SERVICE);
        chk("bp_one_save", n_save - base_save, 1);
        chk("bp_one_pcload", n_pcl - base_pcl, 1);
        Stack_Ack = 1'b1;

        // Three edges during SERVICE: held off until RESTORE, then one entry
        base_save = n_save;
        repeat (3) begin
            INTR = 1'b1; tick(); tick();
            INTR = 1'b0; tick(); tick();
        end
        chk_o("nest_still_svc", O_SERVICE);
        repeat (4) tick();
        chk_o("nest_svc_late", O_SERVICE);
        PC_in = 8'h77; Vec_Data = 8'hA5;
        Is_RTI = 1'b1;
        tick(); Is_RTI = 1'b0;
        chk_o("nest_restore", O_RESTORE);
        tick(); chk_o("nest_idle", O_IDLE);
        tick(); chk_o("nest_drain", O_DRAIN);
        tick(); chk_o("nest_save", O_SAVE);
        tick(); chk_o("nest_push", mk(1, 0, 0, 1, 8'h77, 0, 8'h00, 0, 8'h00, 0));
        tick(); chk_o("nest_fetch", O_FETCH);
        tick(); chk_o("nest_load", mk(1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hA5, 0));
        tick(); chk_o("nest_service", O_SERVICE);
        Is_RTI = 1'b1;
        tick(); Is_RTI = 1'b0;
        tick(); repeat (8) tick();
        chk_o("nest_final_idle", O_IDLE);
        chk("nest_one_entry", n_save - base_save, 1);

        // Reset mid-op in PUSH
        base_pcl = n_pcl;
        PC_in = 8'h42; Stack_Ack = 1'b0;
        INTR = 1'b1;
        tick(); tick(); tick(); INTR = 1'b0;
        tick(); tick(); tick();
        chk_o("rst_in_push", mk(1, 0, 0, 1, 8'h42, 0, 8'h00, 0, 8'h00, 0));
        #2 RST = 1'b1;
        #1 chk_o("rst_async", O_IDLE);
        tick(); RST = 1'b0; Stack_Ack = 1'b1;
        repeat (8) tick();
        chk_o("rst_stay_idle", O_IDLE);
        chk("rst_no_pcload", n_pcl - base_pcl, 0);

        // INTR held 20 cycles: one entry
        base_save = n_save;
        INTR = 1'b1;
        repeat (20) tick();
        INTR = 1'b0;
        chk_o("held_service", O_SERVICE);
        Is_RTI = 1'b1; tick(); Is_RTI = 1'b0;
        repeat (6) tick();
        chk_o("held_idle", O_IDLE);
        chk("held_one_entry", n_save - base_save, 1);

        // Short pulse straddling a rising edge: captured
        base_save = n_save;
        #7 INTR = 1'b1;
        #4 INTR = 1'b0;
        tick();
        repeat (9) tick();
        chk_o("glitch_cap_svc", O_SERVICE);
        Is_RTI = 1'b1; tick(); Is_RTI = 1'b0;
        tick(); tick();
        chk("glitch_cap_one", n_save - base_save, 1);

        // Short pulse between edges: not captured
        base_save = n_save;
        #2 INTR = 1'b1;
        #3 INTR = 1'b0;
        repeat (10) tick();
        chk_o("glitch_miss_idle", O_IDLE);
        chk("glitch_miss_none", n_save - base_save, 0);

        chk("no_overlap", n_overlap, 0);
        chk("pulse_width", n_long, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
